// File: rtl/seq_div_16.sv
// seq_div_16: multi-cycle restoring shift-subtract divider, one quotient bit per clock.
// Optional feature macro DIV_SIGNED_EN selects two's-complement signed division (default unsigned).
module seq_div_16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nxt;

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] q_sh;
    logic [WIDTH-1:0] dvsr;
    // The partial remainder only reaches WIDTH bits on the final iteration,
    // so the stored copy drops its MSB; the full value goes straight to the output.
    logic [WIDTH-2:0] r_acc;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_next;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH:0]   diff;
    logic             accept;
    logic             accept_dbz;
    logic             last_iter;

`ifdef DIV_SIGNED_EN
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic neg_q;
    logic neg_r;

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        return ~v + ONE;
    endfunction

    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
        logic [WIDTH-1:0] u;
        u = v;
        return u[WIDTH-1] ? negate(u) : u;
    endfunction

    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? negate(v) : v;
    endfunction
`endif

    assign accept     = start && (state != RUN);
    assign accept_dbz = accept && (divisor == '0);
    assign last_iter  = (state == RUN) && (cnt == LAST_CNT);
    assign busy       = (state == RUN);
    assign done       = (state == DONE);

    // One iteration: shift in the next dividend bit, trial-subtract as A + ~B + 1.
    always_comb begin
        r_shift = {r_acc, q_sh[WIDTH-1]};
        diff    = {1'b0, r_shift} + {1'b1, ~dvsr} + {{WIDTH{1'b0}}, 1'b1};
        if (!diff[WIDTH]) begin
            r_next = diff[WIDTH-1:0];
            q_next = {q_sh[WIDTH-2:0], 1'b1};
        end else begin
            r_next = r_shift;
            q_next = {q_sh[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (accept) begin
                    state_nxt = accept_dbz ? DONE : RUN;
                end else if (state == DONE) begin
                    state_nxt = IDLE;
                end
            end
            RUN: begin
                if (last_iter) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Control and visible results: cleared by reset, results written only on DONE entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            if (accept) begin
                cnt <= '0;
            end else if (state == RUN) begin
                cnt <= cnt + CNT_W'(1);
            end

            if (accept_dbz) begin
                quotient    <= '1;
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end else if (accept) begin
                div_by_zero <= 1'b0;
            end else if (last_iter) begin
`ifdef DIV_SIGNED_EN
                quotient  <= apply_sign(q_next, neg_q);
                remainder <= apply_sign(r_next, neg_r);
`else
                quotient  <= q_next;
                remainder <= r_next;
`endif
            end
        end
    end

    // Working datapath registers need no reset: they are always loaded before use.
    always_ff @(posedge clk) begin
        if (accept && !accept_dbz) begin
            r_acc <= '0;
`ifdef DIV_SIGNED_EN
            q_sh  <= magnitude(dividend);
            dvsr  <= magnitude(divisor);
            neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_r <= dividend[WIDTH-1];
`else
            q_sh  <= dividend;
            dvsr  <= divisor;
`endif
        end else if (state == RUN) begin
            r_acc <= r_next[WIDTH-2:0];
            q_sh  <= q_next;
        end
    end

endmodule

// File: tb/tb_seq_div_16.sv
// tb_seq_div_16: table-driven directed vectors plus hand-written multi-cycle sequences for seq_div_16.
module tb_seq_div_16;
    localparam int WIDTH = 16;
    localparam int TIMEOUT = 40;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] q;
        logic [15:0] r;
        logic        dbz;
    } vec_t;

    vec_t vecs[$];

    seq_div_16 #(.WIDTH(WIDTH)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .dividend(dividend),
        .divisor(divisor),
        .busy(busy),
        .done(done),
        .quotient(quotient),
        .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_start(input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    // Counts negedges after the accepting edge until done is seen (bounded).
    task automatic wait_done(input int lat0, output int lat, output logic bs);
        lat = lat0;
        bs  = busy;
        while (!done && lat < TIMEOUT) begin
            @(negedge clk);
            lat++;
            bs = bs | busy;
        end
    endtask

    task automatic check_result(input string tag, input vec_t v, input int lat, input logic bs);
        int elat;
        elat = v.dbz ? 0 : WIDTH;
        check($sformatf("%s_latency", tag), lat, elat);
        check($sformatf("%s_done", tag), {31'd0, done}, 32'd1);
        check($sformatf("%s_quotient", tag), {16'd0, quotient}, {16'd0, v.q});
        check($sformatf("%s_remainder", tag), {16'd0, remainder}, {16'd0, v.r});
        check($sformatf("%s_dbz", tag), {31'd0, div_by_zero}, {31'd0, v.dbz});
        check($sformatf("%s_busy_seen", tag), {31'd0, bs}, {31'd0, !v.dbz});
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        int   lat;
        logic bs;
        apply_start(v.a, v.b);
        wait_done(0, lat, bs);
        check_result(tag, v, lat, bs);
        @(negedge clk);
        check($sformatf("%s_done_one_cycle", tag), {31'd0, done}, 32'd0);
        check($sformatf("%s_q_held", tag), {16'd0, quotient}, {16'd0, v.q});
    endtask

    initial begin
        int   lat;
        logic bs;
        logic seen;
        vec_t v1;
        vec_t v2;

        // Common vectors: same meaning in unsigned and signed builds.
        vecs.push_back('{16'd100,   16'd7,      16'd14,     16'd2,      1'b0});
        vecs.push_back('{16'h1234,  16'h0000,   16'hFFFF,   16'h1234,   1'b1});
        vecs.push_back('{16'd9,     16'd3,      16'd3,      16'd0,      1'b0});
        vecs.push_back('{16'd0,     16'd5,      16'd0,      16'd0,      1'b0});
        vecs.push_back('{16'd1000,  16'd33,     16'd30,     16'd10,     1'b0});
        vecs.push_back('{16'h7FFF,  16'h0100,   16'h007F,   16'h00FF,   1'b0});
        vecs.push_back('{16'hFFFF,  16'hFFFF,   16'h0001,   16'h0000,   1'b0});
        vecs.push_back('{16'h0000,  16'h0000,   16'hFFFF,   16'h0000,   1'b1});
`ifdef DIV_SIGNED_EN
        vecs.push_back('{16'hFFF9,  16'h0002,   16'hFFFD,   16'hFFFF,   1'b0});
        vecs.push_back('{16'h0007,  16'hFFFE,   16'hFFFD,   16'h0001,   1'b0});
        vecs.push_back('{16'h8000,  16'hFFFF,   16'h8000,   16'h0000,   1'b0});
        vecs.push_back('{16'hFF9C,  16'hFFF9,   16'h000E,   16'hFFFE,   1'b0});
        v1 = '{16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0};
        v2 = '{16'h0005, 16'hFFFF, 16'hFFFB, 16'h0000, 1'b0};
`else
        vecs.push_back('{16'hFFFE,  16'h8001,   16'h0001,   16'h7FFD,   1'b0});
        vecs.push_back('{16'hABCD,  16'h0010,   16'h0ABC,   16'h000D,   1'b0});
        vecs.push_back('{16'hC000,  16'h00C0,   16'h0100,   16'h0000,   1'b0});
        v1 = '{16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0};
        v2 = '{16'h0005, 16'hFFFF, 16'h0000, 16'h0005, 1'b0};
`endif

        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_quotient", {16'd0, quotient}, 32'd0);
        check("reset_remainder", {16'd0, remainder}, 32'd0);
        check("reset_dbz", {31'd0, div_by_zero}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", {31'd0, busy}, 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // Back-to-back: start held through the DONE cycle.
        apply_start(v1.a, v1.b);
        wait_done(0, lat, bs);
        check_result("b2b_first", v1, lat, bs);
        dividend = v2.a;
        divisor  = v2.b;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("b2b_done_dropped", {31'd0, done}, 32'd0);
        check("b2b_busy_restart", {31'd0, busy}, 32'd1);
        check("b2b_q_held_in_run", {16'd0, quotient}, {16'd0, v1.q});
        wait_done(0, lat, bs);
        check_result("b2b_second", v2, lat, bs);

        // Start pulsed mid-RUN must be ignored.
        apply_start(16'd100, 16'd7);
        repeat (5) @(negedge clk);
        check("midrun_q_not_visible", {16'd0, quotient}, {16'd0, v2.q});
        dividend = 16'd200;
        divisor  = 16'd3;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(6, lat, bs);
        check_result("midrun", '{16'd100, 16'd7, 16'd14, 16'd2, 1'b0}, lat, bs);

        // Asynchronous abort eight cycles into RUN.
        apply_start(16'd1000, 16'd33);
        repeat (7) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_quotient", {16'd0, quotient}, 32'd0);
        check("abort_remainder", {16'd0, remainder}, 32'd0);
        check("abort_dbz", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            seen = seen | done | busy;
        end
        check("abort_no_done", {31'd0, seen}, 32'd0);
        run_vec("after_abort", '{16'd50, 16'd6, 16'd8, 16'd2, 1'b0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
